// File: rtl/fetch_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_hazard_ctrl_pkg
// Shared types and default sizing for the fetch-stage hazard controller.
//   ctrl_state_t : controller state (IDLE / RUN / MEM_WAIT / HALT)
//   DEF_*        : default parameter values. ADDR_W matches the fetch stage PC.
// -----------------------------------------------------------------------------
package fetch_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } ctrl_state_t;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_REG_W   = 4;
    localparam int DEF_MEM_LAT = 4;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/fetch_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. It flags when the instruction in
// ID reads a register that the load currently in EX is about to write.
//   i_id_rs1/i_id_rs2        : ID source register specifiers
//   i_id_uses_rs1/_rs2       : ID instruction actually reads that source
//   i_ex_mem_read            : EX instruction is a load
//   i_ex_rd                  : EX destination register
//   o_load_use               : stall required
// -----------------------------------------------------------------------------
module hazard_detect #(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    output logic             o_load_use
);

    logic w_rd_nonzero;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign w_rd_nonzero = (i_ex_rd != '0);
    assign w_rs1_hit    = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit    = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_load_use   = i_ex_mem_read && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_hazard_ctrl
// Fetch-stage pipeline controller for the SIMD AES core. Each cycle it decides
// whether fetch advances, holds or redirects, and drives the IF/ID and ID/EX
// enables/flushes accordingly.
//   clk, rst          : clock, synchronous active-high reset
//   start             : pulse to leave IDLE and begin fetching
//   id_*              : hazard-relevant fields of the instruction in ID
//   ex_*              : load / vector-memory / branch status of EX
//   pc_write, branch, branch_addr : fetch-stage PC control
//   ifid_en, ifid_flush, idex_flush : pipeline register control
//   busy              : controller in RUN or MEM_WAIT
//   stall_count       : saturating count of busy cycles with pc_write low
// Control outputs are combinational so stalls take effect in the same cycle.
// -----------------------------------------------------------------------------
module fetch_hazard_ctrl
    import fetch_hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_halt,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_vmem,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    output logic              pc_write,
    output logic              branch,
    output logic [ADDR_W-1:0] branch_addr,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_count
);

    // Wait counter only has to hold MEM_LAT-1.
    localparam int              LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_next;
    logic [LAT_W-1:0] r_wait_cnt;
    logic [LAT_W-1:0] w_wait_cnt_next;
    logic [LAT_W-1:0] w_wait_cnt_dec;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_load_use;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .i_ex_mem_read (ex_mem_read),
        .i_ex_rd       (ex_rd),
        .o_load_use    (w_load_use)
    );

    assign w_wait_cnt_dec = r_wait_cnt - LAT_W'(1);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (busy && !pc_write && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ex_branch_taken) begin
                    w_state_next = ST_RUN;
                end else if (ex_vmem) begin
                    // The RUN entry cycle is the first of MEM_LAT hold cycles;
                    // with MEM_LAT=1 that single cycle is the whole stall.
                    if (MEM_LAT > 1) begin
                        w_state_next    = ST_MEM_WAIT;
                        w_wait_cnt_next = LAT_LOAD;
                    end
                end else if (w_load_use) begin
                    w_state_next = ST_RUN;
                end else if (id_halt) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_MEM_WAIT: begin
                // Counter holds the wait cycles left including this one; leave
                // once it has counted down to zero.
                w_wait_cnt_next = w_wait_cnt_dec;
                if (w_wait_cnt_dec == '0) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        branch_addr = '0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_RUN: begin
                busy     = 1'b1;
                pc_write = 1'b1;
                ifid_en  = 1'b1;
                if (ex_branch_taken) begin
                    // Both flushes in one cycle: the two wrong-path slots die.
                    branch      = 1'b1;
                    branch_addr = ex_branch_target;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                end else if (ex_vmem || w_load_use) begin
                    pc_write   = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_halt) begin
                    pc_write = 1'b0;
                    ifid_en  = 1'b0;
                end
            end
            ST_MEM_WAIT: begin
                // EX is frozen by MEM; ex_* inputs are deliberately ignored.
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
module tb_fetch_hazard_ctrl;

    localparam int ADDR_W  = 12;
    localparam int REG_W   = 4;
    localparam int MEM_LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start;
    logic [REG_W-1:0]  id_rs1, id_rs2, ex_rd;
    logic              id_uses_rs1, id_uses_rs2, id_halt;
    logic              ex_mem_read, ex_vmem, ex_branch_taken;
    logic [ADDR_W-1:0] ex_branch_target;

    logic              pc_write, branch, ifid_en, ifid_flush, idex_flush, busy;
    logic [ADDR_W-1:0] branch_addr;
    logic [15:0]       stall_count;

    logic              s_pc_write, s_branch, s_ifid_en, s_ifid_flush, s_idex_flush, s_busy;
    logic [ADDR_W-1:0] s_branch_addr;
    logic [3:0]        s_stall_count;

    fetch_hazard_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W), .MEM_LAT(MEM_LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_vmem(ex_vmem),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .pc_write(pc_write), .branch(branch), .branch_addr(branch_addr), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .busy(busy), .stall_count(stall_count)
    );

    // Narrow stall counter instance to exercise saturation.
    fetch_hazard_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W), .MEM_LAT(MEM_LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_vmem(ex_vmem),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .pc_write(s_pc_write), .branch(s_branch), .branch_addr(s_branch_addr), .ifid_en(s_ifid_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .busy(s_busy), .stall_count(s_stall_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: "running" flag, "halted" flag, and a count of further
    // cycles during which fetch is held by an outstanding vector memory op.
    bit m_active, m_halted;
    int m_hold, m_stalls;
    bit n_active, n_halted;
    int n_hold, n_stalls;
    bit e_pc, e_br, e_ifen, e_iff, e_idf, e_busy;
    logic [ADDR_W-1:0] e_addr;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_eval();
        bit lu;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        e_pc = 0; e_br = 0; e_ifen = 0; e_iff = 0; e_idf = 0; e_busy = 0; e_addr = '0;
        n_active = m_active; n_halted = m_halted; n_hold = m_hold; n_stalls = m_stalls;
        if (m_active) begin
            e_busy = 1;
            if (m_hold > 0) begin
                n_hold = m_hold - 1;
            end else if (ex_branch_taken) begin
                e_pc = 1; e_ifen = 1; e_br = 1; e_addr = ex_branch_target; e_iff = 1; e_idf = 1;
            end else if (ex_vmem) begin
                e_idf = 1; n_hold = MEM_LAT - 1;
            end else if (lu) begin
                e_idf = 1;
            end else if (id_halt) begin
                n_active = 0; n_halted = 1;
            end else begin
                e_pc = 1; e_ifen = 1;
            end
            if (!e_pc) n_stalls = m_stalls + 1;
        end else if (!m_halted && start) begin
            n_active = 1;
        end
        if (rst) begin
            n_active = 0; n_halted = 0; n_hold = 0; n_stalls = 0;
        end
    endtask

    task automatic tick(input string tag);
        #1;
        model_eval();
        check_val({tag, ".pc_write"},    pc_write,    e_pc);
        check_val({tag, ".branch"},      branch,      e_br);
        check_val({tag, ".branch_addr"}, branch_addr, e_addr);
        check_val({tag, ".ifid_en"},     ifid_en,     e_ifen);
        check_val({tag, ".ifid_flush"},  ifid_flush,  e_iff);
        check_val({tag, ".idex_flush"},  idex_flush,  e_idf);
        check_val({tag, ".busy"},        busy,        e_busy);
        check_val({tag, ".stall_count"}, stall_count, sat(m_stalls, 16));
        check_val({tag, ".stall_sat"},   s_stall_count, sat(m_stalls, 4));
        @(posedge clk);
        m_active = n_active; m_halted = n_halted; m_hold = n_hold; m_stalls = n_stalls;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 0; start = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_halt = 0; ex_mem_read = 0; ex_rd = 0; ex_vmem = 0; ex_branch_taken = 0;
        ex_branch_target = 0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_rd = 4'd5; id_rs2 = 4'd5; id_uses_rs2 = 1;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_active = 0; m_halted = 0; m_hold = 0; m_stalls = 0;

        // Reset state, then start.
        tick("reset");
        start = 1; tick("start");
        start = 0; tick("first_fetch");
        check_val("first_fetch_busy", busy, 1);
        $display("TXN start: busy=%0d stall_count=%0d", busy, stall_count);

        // Load-use on rs2.
        set_load_use(); tick("lu");
        clear_inputs(); tick("lu_after");
        check_val("lu_stall_count", stall_count, 1);
        $display("TXN load-use: stall_count=%0d", stall_count);

        // Load to r0 never stalls.
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1; tick("lu_r0");
        clear_inputs();
        $display("TXN load-r0: stall_count=%0d", stall_count);

        // Taken branch alone, with load-use, with halt.
        ex_branch_taken = 1; ex_branch_target = 12'h0A0; tick("br");
        set_load_use(); tick("br_lu");
        clear_inputs(); ex_branch_taken = 1; ex_branch_target = 12'h0A0; id_halt = 1; tick("br_halt");
        clear_inputs(); tick("br_after");
        $display("TXN branch: stall_count=%0d", stall_count);

        // Vector memory op; a branch asserted during the wait must be ignored.
        ex_vmem = 1; tick("vmem_entry");
        clear_inputs(); ex_branch_taken = 1; ex_branch_target = 12'h123;
        for (int i = 0; i < 3; i++) tick("vmem_wait");
        clear_inputs(); tick("vmem_resume");
        check_val("vmem_stall_count", stall_count, 5);
        $display("TXN vmem: stall_count=%0d", stall_count);

        // HALT, ignored start, reset back to IDLE.
        id_halt = 1; tick("halt");
        clear_inputs(); tick("halted");
        start = 1; tick("halt_start");
        start = 0; tick("halt_idle");
        rst = 1; tick("halt_rst");
        rst = 0; tick("after_rst");
        $display("TXN halt: busy=%0d", busy);

        // start and rst together keep IDLE.
        start = 1; rst = 1; tick("start_rst");
        clear_inputs(); tick("start_rst_after");
        $display("TXN start+rst: busy=%0d", busy);

        // Reset in the second MEM_WAIT cycle.
        start = 1; tick("mw_start");
        clear_inputs(); tick("mw_run");
        ex_vmem = 1; tick("mw_entry");
        clear_inputs(); tick("mw_wait1");
        rst = 1; tick("mw_wait2_rst");
        rst = 0; tick("mw_idle");
        check_val("mw_rst_stall_count", stall_count, 0);
        $display("TXN reset-mid-wait: busy=%0d stall_count=%0d", busy, stall_count);

        // Saturation: 20 back-to-back load-use stalls.
        start = 1; tick("sat_start");
        clear_inputs(); set_load_use();
        for (int i = 0; i < 20; i++) tick("sat_lu");
        clear_inputs(); tick("sat_after");
        check_val("sat_narrow", s_stall_count, 4'hF);
        check_val("sat_wide", stall_count, 20);
        $display("TXN saturation: wide=%0d narrow=%0d", stall_count, s_stall_count);

        // Randomized traffic.
        for (int b = 0; b < 30; b++) begin
            for (int c = 0; c < 50; c++) begin
                clear_inputs();
                rst              = ($urandom_range(0, 39) == 0);
                start            = ($urandom_range(0, 7) == 0);
                id_rs1           = REG_W'($urandom_range(0, 3));
                id_rs2           = REG_W'($urandom_range(0, 3));
                id_uses_rs1      = $urandom_range(0, 1);
                id_uses_rs2      = $urandom_range(0, 1);
                id_halt          = ($urandom_range(0, 29) == 0);
                ex_mem_read      = ($urandom_range(0, 2) == 0);
                ex_rd            = REG_W'($urandom_range(0, 3));
                ex_vmem          = ($urandom_range(0, 9) == 0);
                ex_branch_taken  = ($urandom_range(0, 7) == 0);
                ex_branch_target = ADDR_W'($urandom);
                tick("rand");
            end
            $display("TXN random burst %0d: busy=%0d stall_count=%0d", b, busy, stall_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_hazard_ctrl.md
# fetch_hazard_ctrl

Pipeline control unit for the SIMD AES core's fetch stage. It decides every cycle whether the instruction fetch stage advances, holds or redirects. It drives the fetch stage's PC write-enable, branch select and branch target, plus the IF/ID and ID/EX pipeline-register enables and flushes. It handles start/halt sequencing, load-use stalls, multi-cycle vector memory waits and taken branches resolved in EX.

## Interface
Parameters:
- ADDR_W, 12, PC / instruction address width
- REG_W, 4, register specifier width
- MEM_LAT, 4, cycles a vector memory op occupies the MEM stage (≥1)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: leave IDLE and begin fetching
- id_rs1, id_rs2  in  REG_W each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source
- id_halt  in  1  instruction in ID is HALT
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination register of the instruction in EX
- ex_vmem  in  1  instruction in EX is a vector memory op (multi-cycle)
- ex_branch_taken  in  1  branch in EX resolved taken
- ex_branch_target  in  ADDR_W  target of that branch
- pc_write  out  1  fetch-stage PC write-enable
- branch  out  1  fetch-stage PC mux select (1 = target)
- branch_addr  out  ADDR_W  fetch-stage branch address
- ifid_en  out  1  IF/ID register write-enable
- ifid_flush  out  1  IF/ID register clear (insert NOP)
- idex_flush  out  1  ID/EX register clear (insert bubble)
- busy  out  1  state is not IDLE or HALT
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0 while busy

## Operation
- States: IDLE, RUN, MEM_WAIT, HALT.
- IDLE: all enables 0, flushes 0. On start, go to RUN.
- RUN: the default is pc_write=1, ifid_en=1, branch=0. Conditions are evaluated in priority order:
  1. ex_branch_taken: pc_write=1, branch=1, branch_addr=ex_branch_target, ifid_flush=1, idex_flush=1. Stay in RUN.
  2. ex_vmem: pc_write=0, ifid_en=0, idex_flush=1. Load wait counter with MEM_LAT-1. Go to MEM_WAIT. If MEM_LAT=1, behave as a 1-cycle stall and stay in RUN.
  3. Load-use: ex_mem_read and ex_rd≠0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)). Response: pc_write=0, ifid_en=0, idex_flush=1 for exactly one cycle.
  4. id_halt: pc_write=0, ifid_en=0, idex_flush=0. Go to HALT. HALT propagates down the pipe.
- MEM_WAIT: pc_write=0, ifid_en=0, idex_flush=0. Decrement the counter. When counter==0 and not rst, go to RUN. ex_* inputs are ignored; EX is frozen by the MEM stage.
- HALT: all enables 0. Exit only via rst. A start pulse is ignored.
- branch_addr = ex_branch_target whenever branch=1, else 0.
- Register 0 is hardwired, so ex_rd==0 never causes a stall.
- stall_count increments when busy and pc_write=0. It saturates at all-ones.

## Timing
- Control outputs are combinational from the current state and inputs, with the same-cycle effect needed for stalls. State, counter and stall_count are registered.
- Reset (rst high at a clock edge): state=IDLE, counter=0, stall_count=0. All outputs are therefore 0. Reset wins over every input, including mid-MEM_WAIT and same-cycle start.
- start and rst both high in the same cycle: the block remains in IDLE.
- The first fetch PC advance happens in the cycle after the start pulse.
- A taken branch costs 2 bubbles: the IF/ID and ID/EX flushes happen in the same cycle. The new PC is visible the next cycle.
- MEM_WAIT holds fetch for MEM_LAT cycles total, counting the entry cycle in RUN.
- Branch and load-use asserted in the same cycle: the branch wins and no stall is taken.
- Branch and id_halt asserted in the same cycle: the branch wins. The HALT instruction is flushed.

## Structure
- The shared package holds the state enum type ctrl_state_t and the default parameter constants. ADDR_W=12 matches the fetch stage.
- One sub-module, hazard_detect: the purely combinational load-use comparator.
- The FSM, counter and stall counter live in the top.

## Test plan
- Reset then start: cycle 0 start=1 -> cycle 1 busy=1, pc_write=1, ifid_en=1, all flushes 0, stall_count=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> exactly 1 cycle of pc_write=0, ifid_en=0, idex_flush=1, then normal. stall_count=1.
- Taken branch: ex_branch_taken=1, target=12'h0A0 -> same cycle branch=1, branch_addr=0x0A0, pc_write=1, ifid_flush=1, idex_flush=1. Also with load-use asserted simultaneously -> same response, no stall.
- Vector memory op with MEM_LAT=4: ex_vmem=1 -> pc_write=0 for 4 consecutive cycles, then pc_write=1. stall_count=4.
- HALT: id_halt=1 -> pc_write=0, busy=0 from the next cycle. A start pulse has no effect. rst returns to IDLE.
- Reset mid-MEM_WAIT (second wait cycle): rst=1 -> next cycle state IDLE, all outputs 0, stall_count=0.
- Saturation: with CNT_W=4, force 20 stall cycles -> stall_count holds 4'hF.
